// File: rtl/upg_loader_pkg.sv
// Shared types and constants for the UART programmer loader.
package upg_loader_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_DONE, ST_ERROR
    } upg_state_e;

    localparam logic        UPG_TGT_INSTR = 1'b0;
    localparam logic        UPG_TGT_DATA  = 1'b1;
    localparam int          UPG_MAX_WORDS = 16384;
    localparam logic [31:0] ZeroWord      = 32'h0000_0000;

    function automatic logic is_target_byte(input logic [7:0] b);
        return b[7:1] == 7'd0;
    endfunction
endpackage

// File: rtl/upg_loader_if.sv
// Byte-in / memory-write-port bundle between UART receiver, loader and memories.
interface upg_loader_if;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        upg_rst_o;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        err_o;

    modport master (
        output rx_valid_i, rx_data_i,
        input  upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o
    );
    modport slave (
        input  rx_valid_i, rx_data_i,
        output upg_rst_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o
    );
endinterface

// File: rtl/upg_word_assembler.sv
// Collects four bytes LSB-first; word_valid fires combinationally with the 4th byte.
module upg_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;

    assign word_valid = byte_valid && !clear && (byte_cnt == 2'd3);
    assign word       = {byte_data, low_bytes};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (clear) begin
            byte_cnt  <= 2'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    low_bytes[7:0]   <= byte_data;
                2'd1:    low_bytes[15:8]  <= byte_data;
                2'd2:    low_bytes[23:16] <= byte_data;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/upg_loader.sv
// Frame parser and write-port driver for the UART programmer path.
module upg_loader
    import upg_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic         clock,
    input logic         reset,
    upg_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    upg_state_e  state, state_nxt;
    logic        tgt;
    logic [7:0]  cnt_lo;
    logic [14:0] count, index;
    logic [TW-1:0] idle_cnt;
    logic [15:0] count_full;
    logic        count_ok, in_frame, timeout, last_word, tgt_byte;
    logic        word_valid;
    logic [31:0] word;
    logic        wen_q;
    logic [14:0] adr_q;
    logic [31:0] dat_q;

    upg_word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (state != ST_DATA),
        .byte_valid (bus.rx_valid_i),
        .byte_data  (bus.rx_data_i),
        .word_valid (word_valid),
        .word       (word)
    );

    assign count_full = {bus.rx_data_i, cnt_lo};
    assign count_ok   = (count_full != 16'd0) && (count_full <= 16'(UPG_MAX_WORDS));
    assign in_frame   = (state == ST_CNT_LO) || (state == ST_CNT_HI) || (state == ST_DATA);
    // An arriving byte beats the threshold in the same cycle.
    assign timeout    = in_frame && !bus.rx_valid_i && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_word  = word_valid && ((index + 15'd1) == count);
    assign tgt_byte   = is_target_byte(bus.rx_data_i);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = ST_ERROR;
        end else begin
            case (state)
                ST_IDLE, ST_DONE:
                    if (bus.rx_valid_i) begin
                        if (tgt_byte)              state_nxt = ST_CNT_LO;
                        else if (state == ST_IDLE) state_nxt = ST_ERROR;
                    end
                ST_CNT_LO: if (bus.rx_valid_i) state_nxt = ST_CNT_HI;
                ST_CNT_HI: if (bus.rx_valid_i) state_nxt = count_ok ? ST_DATA : ST_ERROR;
                ST_DATA:   if (last_word)      state_nxt = ST_DONE;
                default:   state_nxt = ST_ERROR;
            endcase
        end
    end

    // DONE keeps the CPU in programming mode; it runs via the done override.
    always_comb begin
        bus.upg_rst_o  = !(in_frame || (state == ST_DONE));
        bus.upg_done_o = (state == ST_DONE);
        bus.err_o      = (state == ST_ERROR);
        bus.upg_wen_o  = wen_q;
        bus.upg_adr_o  = adr_q;
        bus.upg_dat_o  = dat_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tgt      <= UPG_TGT_INSTR;
            cnt_lo   <= 8'd0;
            count    <= 15'd0;
            index    <= 15'd0;
            idle_cnt <= '0;
            wen_q    <= 1'b0;
            adr_q    <= 15'd0;
            dat_q    <= ZeroWord;
        end else begin
            wen_q <= word_valid;
            if ((state == ST_IDLE || state == ST_DONE) && bus.rx_valid_i && tgt_byte)
                tgt <= bus.rx_data_i[0] ? UPG_TGT_DATA : UPG_TGT_INSTR;
            if (state == ST_CNT_LO && bus.rx_valid_i)
                cnt_lo <= bus.rx_data_i;
            if (state == ST_CNT_HI && bus.rx_valid_i) begin
                count <= count_full[14:0];
                index <= 15'd0;
            end
            if (word_valid) begin
                adr_q <= {tgt, index[13:0]};
                dat_q <= word;
                index <= index + 15'd1;
            end
            if (!in_frame || bus.rx_valid_i) idle_cnt <= '0;
            else if (!timeout)               idle_cnt <= idle_cnt + 1'b1;
        end
    end
endmodule
